// File: rtl/fold_tap_sequencer_if.sv
// fold_tap_sequencer_if: sample handshake and tap-RAM / coefficient bus.
// Ports: datain/datavalid in; ready/overrun, ram_*, coef_addr, first/last_tap out.
interface fold_tap_sequencer_if #(
   parameter int WIDTH   = 16,
   parameter int LOGTAPS = 3
);
   logic [WIDTH-1:0]   datain;
   logic               datavalid;
   logic               ready;
   logic               overrun;
   logic               ram_we;
   logic [LOGTAPS-1:0] ram_waddr;
   logic [WIDTH-1:0]   ram_di;
   logic               ram_rd;
   logic [LOGTAPS-1:0] ram_raddr;
   logic [LOGTAPS-1:0] coef_addr;
   logic               first_tap;
   logic               last_tap;

   modport master (
      output datain, datavalid,
      input  ready, overrun, ram_we, ram_waddr, ram_di,
      input  ram_rd, ram_raddr, coef_addr, first_tap, last_tap
   );

   modport slave (
      input  datain, datavalid,
      output ready, overrun, ram_we, ram_waddr, ram_di,
      output ram_rd, ram_raddr, coef_addr, first_tap, last_tap
   );
endinterface

// File: rtl/fold_tap_sequencer.sv
// fold_tap_sequencer: circular tap-buffer writer and newest-to-oldest scanner.
// Ports: clk, nGrst (async), rst (sync), clkEn; bus = fold_tap_sequencer_if.slave.
module fold_tap_sequencer #(
   parameter int TAPS    = 8,
   parameter int LOGTAPS = 3,
   parameter int WIDTH   = 16,
   parameter int RAM_LAT = 1
) (
   input  logic clk,
   input  logic nGrst,
   input  logic rst,
   input  logic clkEn,
   fold_tap_sequencer_if.slave bus
);

   typedef enum logic [1:0] {INIT, IDLE, SCAN} state_t;

   localparam logic [LOGTAPS-1:0] LAST = LOGTAPS'(TAPS - 1);

   state_t             state;
   logic [LOGTAPS-1:0] wr_ptr;
   logic [LOGTAPS-1:0] init_cnt;
   logic [LOGTAPS-1:0] sp;
   logic [LOGTAPS-1:0] cc;
   logic               ready_r;
   logic               ovr_r;
   logic               we_r;
   logic               rd_r;
   logic               first_s;
   logic               last_s;
   logic [LOGTAPS-1:0] waddr_r;
   logic [LOGTAPS-1:0] raddr_r;
   logic [LOGTAPS-1:0] coef_r;
   logic [WIDTH-1:0]   di_r;
   logic [RAM_LAT-1:0] first_d;
   logic [RAM_LAT-1:0] last_d;

   // State names the action taken at the next enabled edge;
   // all outputs are registered from that action.
   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         state    <= INIT;
         wr_ptr   <= '0;
         init_cnt <= '0;
         sp       <= '0;
         cc       <= '0;
         ready_r  <= 1'b0;
         ovr_r    <= 1'b0;
         we_r     <= 1'b0;
         rd_r     <= 1'b0;
         first_s  <= 1'b0;
         last_s   <= 1'b0;
         waddr_r  <= '0;
         raddr_r  <= '0;
         coef_r   <= '0;
         di_r     <= '0;
         first_d  <= '0;
         last_d   <= '0;
      end else if (rst) begin
         state    <= INIT;
         wr_ptr   <= '0;
         init_cnt <= '0;
         sp       <= '0;
         cc       <= '0;
         ready_r  <= 1'b0;
         ovr_r    <= 1'b0;
         we_r     <= 1'b0;
         rd_r     <= 1'b0;
         first_s  <= 1'b0;
         last_s   <= 1'b0;
         waddr_r  <= '0;
         raddr_r  <= '0;
         coef_r   <= '0;
         di_r     <= '0;
         first_d  <= '0;
         last_d   <= '0;
      end else if (clkEn) begin
         ovr_r   <= bus.datavalid & ~ready_r;
         // Markers ride alongside RAM read latency.
         first_d <= RAM_LAT'({first_d, first_s});
         last_d  <= RAM_LAT'({last_d, last_s});
         unique case (state)
            INIT: begin
               we_r    <= 1'b1;
               di_r    <= '0;
               waddr_r <= init_cnt;
               ready_r <= 1'b0;
               if (init_cnt == LAST) begin
                  init_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            IDLE: begin
               rd_r    <= 1'b0;
               first_s <= 1'b0;
               last_s  <= 1'b0;
               if (ready_r && bus.datavalid) begin
                  ready_r <= 1'b0;
                  we_r    <= 1'b1;
                  waddr_r <= wr_ptr;
                  di_r    <= bus.datain;
                  sp      <= wr_ptr;
                  cc      <= '0;
                  state   <= SCAN;
               end else begin
                  we_r    <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            SCAN: begin
               we_r    <= 1'b0;
               rd_r    <= 1'b1;
               raddr_r <= sp;
               coef_r  <= cc;
               first_s <= (cc == '0);
               last_s  <= (cc == LAST);
               sp      <= (sp == '0) ? LAST : sp - 1'b1;
               cc      <= cc + 1'b1;
               if (cc == LAST) begin
                  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.ready     = ready_r;
   assign bus.overrun   = ovr_r & clkEn;
   assign bus.ram_we    = we_r & clkEn;
   assign bus.ram_waddr = waddr_r;
   assign bus.ram_di    = di_r;
   assign bus.ram_rd    = rd_r & clkEn;
   assign bus.ram_raddr = raddr_r;
   assign bus.coef_addr = coef_r;
   assign bus.first_tap = first_d[RAM_LAT-1];
   assign bus.last_tap  = last_d[RAM_LAT-1];

endmodule

// File: tb/tb_fold_tap_sequencer.sv
// tb_fold_tap_sequencer: random samples against a tap-history model.
// Ports: none; drives fold_tap_sequencer via fold_tap_sequencer_if.
module tb_fold_tap_sequencer;

   localparam int TAPS    = 8;
   localparam int LOGTAPS = 3;
   localparam int WIDTH   = 16;

   logic clk;
   logic nGrst;
   logic rst;
   logic clkEn;

   fold_tap_sequencer_if #(.WIDTH(WIDTH), .LOGTAPS(LOGTAPS)) bus ();

   fold_tap_sequencer #(
      .TAPS(TAPS), .LOGTAPS(LOGTAPS), .WIDTH(WIDTH), .RAM_LAT(1)
   ) dut (
      .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tap RAM: one-cycle registered read
   logic [WIDTH-1:0] mem [TAPS];
   logic [WIDTH-1:0] rdata;
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_di;
      if (bus.ram_rd) rdata <= mem[bus.ram_raddr];
   end

   // Model: hist[0] newest .. hist[TAPS-1] oldest
   logic [WIDTH-1:0] hist [$];
   int exp_wp;
   int n_chk;
   int n_pass;

   task automatic model_reset;
      hist.delete();
      for (int i = 0; i < TAPS; i++) hist.push_back('0);
      exp_wp = 0;
   endtask

   task automatic model_push(input logic [WIDTH-1:0] v);
      hist.push_front(v);
      void'(hist.pop_back());
      exp_wp = (exp_wp + 1) % TAPS;
   endtask

   task automatic wait_ready;
      int k;
      k = 0;
      while (bus.ready !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (bus.ready !== 1'b1) $display("FAIL ready_wait got %b want 1", bus.ready);
      else n_pass++;
   endtask

   task automatic check_init;
      for (int i = 0; i < TAPS; i++) begin
         @(negedge clk);
         n_chk++;
         if (bus.ram_we !== 1'b1 || bus.ram_waddr !== LOGTAPS'(i) ||
             bus.ram_di !== '0 || bus.ready !== 1'b0)
            $display("FAIL init_%0d got we=%b wa=%0d di=%0h rdy=%b want we=1 wa=%0d di=0 rdy=0",
                     i, bus.ram_we, bus.ram_waddr, bus.ram_di, bus.ready, i);
         else n_pass++;
      end
      @(negedge clk);
      n_chk++;
      if (bus.ready !== 1'b1 || bus.ram_we !== 1'b0)
         $display("FAIL init_done got rdy=%b we=%b want rdy=1 we=0", bus.ready, bus.ram_we);
      else n_pass++;
   endtask

   // Full transaction: capture, write, TAPS-read scan, ready again
   task automatic do_sample(input logic [WIDTH-1:0] v);
      int wp;
      wait_ready();
      bus.datavalid = 1'b1;
      bus.datain    = v;
      @(negedge clk);
      bus.datavalid = 1'b0;
      wp = exp_wp;
      n_chk++;
      if (bus.ram_we !== 1'b1 || bus.ram_waddr !== LOGTAPS'(wp) ||
          bus.ram_di !== v || bus.ready !== 1'b0 || bus.ram_rd !== 1'b0)
         $display("FAIL write got we=%b wa=%0d di=%0h rdy=%b rd=%b want 1 %0d %0h 0 0",
                  bus.ram_we, bus.ram_waddr, bus.ram_di, bus.ready, bus.ram_rd, wp, v);
      else n_pass++;
      model_push(v);
      for (int i = 0; i < TAPS; i++) begin
         @(negedge clk);
         n_chk++;
         if (bus.ram_rd !== 1'b1 || bus.ram_we !== 1'b0 ||
             bus.ram_raddr !== LOGTAPS'((wp + TAPS - i) % TAPS) ||
             bus.coef_addr !== LOGTAPS'(i) || bus.ready !== 1'b0)
            $display("FAIL scan_%0d got rd=%b we=%b ra=%0d ca=%0d rdy=%b want 1 0 %0d %0d 0",
                     i, bus.ram_rd, bus.ram_we, bus.ram_raddr, bus.coef_addr, bus.ready,
                     (wp + TAPS - i) % TAPS, i);
         else n_pass++;
         n_chk++;
         if (bus.first_tap !== (i == 1) || bus.last_tap !== 1'b0)
            $display("FAIL mark_%0d got f=%b l=%b want f=%b l=0",
                     i, bus.first_tap, bus.last_tap, i == 1);
         else n_pass++;
         if (i > 0) begin
            n_chk++;
            if (rdata !== hist[i-1])
               $display("FAIL tap_%0d got %0h want %0h", i - 1, rdata, hist[i-1]);
            else n_pass++;
         end
      end
      @(negedge clk);
      n_chk++;
      if (bus.ready !== 1'b1 || bus.ram_rd !== 1'b0 || bus.last_tap !== 1'b1 ||
          bus.first_tap !== 1'b0 || rdata !== hist[TAPS-1] || bus.overrun !== 1'b0)
         $display("FAIL scan_end got rdy=%b rd=%b l=%b f=%b d=%0h ov=%b want 1 0 1 0 %0h 0",
                  bus.ready, bus.ram_rd, bus.last_tap, bus.first_tap, rdata,
                  bus.overrun, hist[TAPS-1]);
      else n_pass++;
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (bus.ram_we !== 1'b0 || bus.ram_rd !== 1'b0 || bus.ready !== 1'b0 ||
          bus.overrun !== 1'b0 || bus.first_tap !== 1'b0 || bus.last_tap !== 1'b0 ||
          bus.ram_waddr !== '0 || bus.ram_raddr !== '0 || bus.coef_addr !== '0 ||
          bus.ram_di !== '0)
         $display("FAIL reset_outputs got we=%b rd=%b rdy=%b ov=%b want all 0",
                  bus.ram_we, bus.ram_rd, bus.ready, bus.overrun);
      else n_pass++;
      nGrst = 1'b1;
      model_reset();
      check_init();
   endtask

   task automatic test_first_sample;
      do_sample(16'h0011);
   endtask

   task automatic test_random;
      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_sample(WIDTH'($urandom));
      end
   endtask

   task automatic test_overrun;
      logic [WIDTH-1:0] v;
      logic pr;
      logic pdv;
      int nov;
      int nwe;
      int k;
      nov = 0;
      nwe = 0;
      wait_ready();
      v = WIDTH'($urandom);
      bus.datavalid = 1'b1;
      bus.datain    = v;
      pr  = bus.ready;
      pdv = 1'b1;
      for (k = 1; k <= 100; k++) begin
         @(negedge clk);
         n_chk++;
         if (bus.overrun !== (pdv && !pr))
            $display("FAIL overrun_%0d got %b want %b", k, bus.overrun, pdv && !pr);
         else n_pass++;
         nov += int'(bus.overrun);
         nwe += int'(bus.ram_we);
         if (k == 1) begin
            n_chk++;
            if (bus.ram_di !== v || bus.ram_waddr !== LOGTAPS'(exp_wp))
               $display("FAIL ovr_write got di=%0h wa=%0d want %0h %0d",
                        bus.ram_di, bus.ram_waddr, v, exp_wp);
            else n_pass++;
         end
         pr  = bus.ready;
         pdv = bus.datavalid;
         if (bus.ready === 1'b1) break;
         bus.datain = WIDTH'($urandom);
      end
      bus.datavalid = 1'b0;
      model_push(v);
      n_chk++;
      if (nwe != 1 || nov != TAPS + 1 || k != TAPS + 2)
         $display("FAIL ovr_counts got we=%0d ov=%0d len=%0d want 1 %0d %0d",
                  nwe, nov, k, TAPS + 1, TAPS + 2);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (bus.ram_we !== 1'b0 || bus.overrun !== 1'b0 || bus.ready !== 1'b1)
         $display("FAIL ovr_after got we=%b ov=%b rdy=%b want 0 0 1",
                  bus.ram_we, bus.overrun, bus.ready);
      else n_pass++;
      do_sample(WIDTH'($urandom));
   endtask

   task automatic test_clken;
      logic [LOGTAPS-1:0] ra [$];
      logic [LOGTAPS-1:0] ca [$];
      logic [WIDTH-1:0] v;
      int en_cycles;
      int wp;
      en_cycles = 0;
      wait_ready();
      v = WIDTH'($urandom);
      bus.datavalid = 1'b1;
      bus.datain    = v;
      @(negedge clk);
      bus.datavalid = 1'b0;
      wp = exp_wp;
      n_chk++;
      if (bus.ram_we !== 1'b1 || bus.ram_waddr !== LOGTAPS'(wp))
         $display("FAIL ce_write got we=%b wa=%0d want 1 %0d", bus.ram_we, bus.ram_waddr, wp);
      else n_pass++;
      model_push(v);
      for (int k = 0; k < 100; k++) begin
         clkEn = (k % 2 == 1);
         @(negedge clk);
         if (clkEn === 1'b0) begin
            n_chk++;
            if (bus.ram_rd !== 1'b0 || bus.ram_we !== 1'b0 || bus.overrun !== 1'b0)
               $display("FAIL ce_off got rd=%b we=%b ov=%b want 0 0 0",
                        bus.ram_rd, bus.ram_we, bus.overrun);
            else n_pass++;
         end else begin
            en_cycles++;
            if (bus.ram_rd === 1'b1) begin
               ra.push_back(bus.ram_raddr);
               ca.push_back(bus.coef_addr);
            end
            if (bus.ready === 1'b1) break;
         end
      end
      clkEn = 1'b1;
      n_chk++;
      if (ra.size() != TAPS || en_cycles != TAPS + 1)
         $display("FAIL ce_count got reads=%0d en=%0d want %0d %0d",
                  ra.size(), en_cycles, TAPS, TAPS + 1);
      else n_pass++;
      for (int i = 0; i < ra.size() && i < TAPS; i++) begin
         n_chk++;
         if (ra[i] !== LOGTAPS'((wp + TAPS - i) % TAPS) || ca[i] !== LOGTAPS'(i))
            $display("FAIL ce_addr_%0d got ra=%0d ca=%0d want %0d %0d",
                     i, ra[i], ca[i], (wp + TAPS - i) % TAPS, i);
         else n_pass++;
      end
      do_sample(WIDTH'($urandom));
   endtask

   task automatic test_rst_abort;
      wait_ready();
      bus.datavalid = 1'b1;
      bus.datain    = WIDTH'($urandom);
      @(negedge clk);
      bus.datavalid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if (bus.ready !== 1'b0 || bus.ram_rd !== 1'b0 || bus.ram_we !== 1'b0 ||
          bus.first_tap !== 1'b0 || bus.last_tap !== 1'b0)
         $display("FAIL abort got rdy=%b rd=%b we=%b f=%b l=%b want all 0",
                  bus.ready, bus.ram_rd, bus.ram_we, bus.first_tap, bus.last_tap);
      else n_pass++;
      model_reset();
      check_init();
   endtask

   task automatic test_back_to_back;
      for (int n = 1; n <= 9; n++) do_sample(WIDTH'(n));
   endtask

   task automatic test_rst_priority;
      wait_ready();
      rst           = 1'b1;
      bus.datavalid = 1'b1;
      bus.datain    = WIDTH'($urandom);
      @(negedge clk);
      rst           = 1'b0;
      bus.datavalid = 1'b0;
      n_chk++;
      if (bus.ram_we !== 1'b0 || bus.ready !== 1'b0)
         $display("FAIL rst_prio got we=%b rdy=%b want 0 0", bus.ram_we, bus.ready);
      else n_pass++;
      model_reset();
      check_init();
      do_sample(WIDTH'($urandom));
   endtask

   initial begin
      n_chk         = 0;
      n_pass        = 0;
      nGrst         = 1'b0;
      rst           = 1'b0;
      clkEn         = 1'b1;
      bus.datavalid = 1'b0;
      bus.datain    = '0;
      test_reset();
      test_first_sample();
      test_random();
      test_overrun();
      test_clken();
      test_rst_abort();
      test_back_to_back();
      test_rst_priority();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
